// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data access.
// One access at a time through a registered grant FSM (IDLE/IGNT/DGNT), and one
// LL/SC link reservation.
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   iREN, iaddr                instruction read request (held until ihit)
//   ihit, iload                instruction done pulse and word
//   dREN, dWEN, datomic        data read/write request (held until dhit); datomic marks LL/SC
//   daddr, dstore              data address and write data
//   dhit, dload                data done pulse; read data, or SC result (1 ok, 0 fail)
//   ramREN, ramWEN             RAM strobes
//   ramaddr, ramstore, ramload RAM address, write data, read data
//   ramstate                   0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
module memory_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          FAIR   = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int unsigned WORD_W    = ADDR_W - 2;
  localparam logic [1:0]  RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t              state, state_nx;
  logic                last_d, last_d_nx;
  logic                link_valid, link_valid_nx;
  logic [WORD_W-1:0]   link_addr, link_addr_nx;

  logic d_req_c;
  logic sc_c;
  logic ll_c;
  logic link_hit_c;

  assign d_req_c    = dREN | dWEN;
  assign sc_c       = dWEN & datomic;
  // write wins over read, so an LL only counts when no write is present
  assign ll_c       = dREN & ~dWEN & datomic;
  assign link_hit_c = link_valid && (link_addr == daddr[ADDR_W-1:2]);

  // State, fairness and link registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      state      <= state_nx;
      last_d     <= last_d_nx;
      link_valid <= link_valid_nx;
      link_addr  <= link_addr_nx;
    end
  end

  // Next state, RAM strobes, hits and link bookkeeping
  always_comb begin
    state_nx      = state;
    last_d_nx     = last_d;
    link_valid_nx = link_valid;
    link_addr_nx  = link_addr;
    ihit          = 1'b0;
    iload         = '0;
    dhit          = 1'b0;
    dload         = '0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;

    case (state)
      IDLE: begin
        if (iREN && d_req_c)  state_nx = (FAIR && last_d) ? IGNT : DGNT;
        else if (d_req_c)     state_nx = DGNT;
        else if (iREN)        state_nx = IGNT;
      end

      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_nx = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          ihit      = 1'b1;
          iload     = ramload;
          last_d_nx = 1'b0;
          state_nx  = IDLE;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req_c) begin
          state_nx = IDLE;
        end else if (sc_c && !link_hit_c) begin
          // failed SC completes at once without touching RAM
          dhit          = 1'b1;
          last_d_nx     = 1'b1;
          link_valid_nx = 1'b0;
          state_nx      = IDLE;
        end else begin
          ramREN = dREN & ~dWEN;
          ramWEN = dWEN;
          if (ramstate == RS_ACCESS) begin
            dhit      = 1'b1;
            last_d_nx = 1'b1;
            state_nx  = IDLE;
            if (sc_c)        dload = DATA_W'(1);
            else if (!dWEN)  dload = ramload;
            if (ll_c) begin
              link_valid_nx = 1'b1;
              link_addr_nx  = daddr[ADDR_W-1:2];
            end
            // any completed write to the reserved word breaks the link
            if (dWEN && link_hit_c) link_valid_nx = 1'b0;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: FAIR=1 instance checked throughout, FAIR=0
// instance shares the inputs and is checked on the arbitration sequence.
module tb_memory_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, datomic;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;

  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        f0_ihit, f0_dhit, f0_ramREN, f0_ramWEN;
  logic [31:0] f0_iload, f0_dload, f0_ramaddr, f0_ramstore;

  int checks = 0;
  int errors = 0;

  logic [31:0] dq[$];
  logic        m_lv;
  logic [29:0] m_la;

  always #5 CLK = ~CLK;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1'b0)) dut0 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(f0_ihit), .iload(f0_iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dhit(f0_dhit), .dload(f0_dload),
    .ramREN(f0_ramREN), .ramWEN(f0_ramWEN), .ramaddr(f0_ramaddr), .ramstore(f0_ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One data request; expected load pushed on issue, popped on dhit.
  task automatic data_access(input logic r, input logic w, input logic a,
                             input logic [31:0] addr, input logic [31:0] st,
                             input int busy, input logic [31:0] rdata);
    logic        fail;
    logic [31:0] exp_load;
    logic [31:0] e;
    int          hit_at;
    fail = w && a && !(m_lv && (m_la == addr[31:2]));
    if (w) exp_load = (a && !fail) ? 32'd1 : 32'd0;
    else   exp_load = rdata;
    dq.push_back(exp_load);

    @(negedge CLK);
    dREN = r; dWEN = w; datomic = a; daddr = addr; dstore = st;
    ramstate = RS_FREE; ramload = rdata;
    #1 chk("idle_before_grant", {61'd0, ramREN, ramWEN, dhit}, 64'd0);

    hit_at = 0;
    for (int c = 1; c <= 20 && hit_at == 0; c++) begin
      @(negedge CLK);
      ramstate = (c <= busy) ? RS_BUSY : RS_ACCESS;
      #1;
      if (dhit) begin
        hit_at = c;
        chk("ramWEN_at_hit", {63'd0, ramWEN}, {63'd0, w && !fail});
        chk("ramREN_at_hit", {63'd0, ramREN}, {63'd0, r && !w});
        chk("ramaddr_at_hit", {32'd0, ramaddr}, {32'd0, addr});
        if (w && !fail) chk("ramstore_at_hit", {32'd0, ramstore}, {32'd0, st});
        e = dq.pop_front();
        chk("dload", {32'd0, dload}, {32'd0, e});
      end
    end
    chk("hit_cycle", 64'(hit_at), fail ? 64'd1 : 64'(busy + 1));
    if (hit_at == 0) dq.delete();

    if (r && !w && a) begin m_lv = 1'b1; m_la = addr[31:2]; end
    if (w && a) m_lv = 1'b0;
    if (w && !a && m_lv && (m_la == addr[31:2])) m_lv = 1'b0;

    @(negedge CLK);
    dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; ramstate = RS_FREE;
    #1 chk("gap_idle", {60'd0, ramREN, ramWEN, dhit, ihit}, 64'd0);
  endtask

  initial begin
    logic [1:0] exp1, exp0;
    int         g;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
    m_lv = 1'b0; m_la = '0;

    // reset state
    @(negedge CLK); @(negedge CLK);
    #1 chk("reset_outputs", {60'd0, ihit, dhit, ramREN, ramWEN}, 64'd0);
    chk("reset_ramaddr", {32'd0, ramaddr}, 64'd0);
    nRST = 1'b1;

    // reset in the middle of a data grant drops it
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h80; ramstate = RS_BUSY; ramload = 32'h5555_AAAA;
    @(negedge CLK);
    #1 chk("dgnt_strobe", {63'd0, ramREN}, 64'd1);
    ramstate = RS_ACCESS; nRST = 1'b0;
    #1 chk("reset_mid_dgnt", {61'd0, dhit, ramREN, ramWEN}, 64'd0);
    chk("reset_mid_ramaddr", {32'd0, ramaddr}, 64'd0);
    @(negedge CLK);
    dREN = 1'b0; ramstate = RS_FREE; nRST = 1'b1;
    #1 chk("after_reset_idle", {61'd0, dhit, ramREN, ramWEN}, 64'd0);

    // tie with last_d=0: data first, then instruction, never both
    @(negedge CLK);
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300;
    ramstate = RS_ACCESS; ramload = 32'h1111_0000;
    #1 chk("tie_idle", {62'd0, ihit, dhit}, 64'd0);
    @(negedge CLK);
    #1 chk("tie_first_d", {62'd0, ihit, dhit}, 64'b01);
    chk("tie_d_addr", {32'd0, ramaddr}, 64'h300);
    chk("tie_d_load", {32'd0, dload}, 64'h1111_0000);
    @(negedge CLK);
    dREN = 1'b0; ramload = 32'h2222_0000;
    #1 chk("tie_gap", {62'd0, ihit, dhit}, 64'd0);
    @(negedge CLK);
    #1 chk("tie_then_i", {62'd0, ihit, dhit}, 64'b10);
    chk("tie_i_load", {32'd0, iload}, 64'h2222_0000);
    chk("tie_i_addr", {32'd0, ramaddr}, 64'h200);
    @(negedge CLK);
    iREN = 1'b0; ramstate = RS_FREE;
    #1 chk("tie_done_idle", {60'd0, ihit, dhit, ramREN, ramWEN}, 64'd0);

    // RAM wait states
    data_access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);

    // LL/SC success, then a repeated SC fails
    data_access(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 0, 32'hAAAA_5555);
    data_access(1'b0, 1'b1, 1'b1, 32'h100, 32'h5, 1, 32'h0);
    data_access(1'b0, 1'b1, 1'b1, 32'h100, 32'h5, 0, 32'h0);

    // plain write to the linked word breaks the link
    data_access(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 0, 32'h0000_1234);
    data_access(1'b0, 1'b1, 1'b0, 32'h100, 32'h7, 2, 32'h0);
    data_access(1'b0, 1'b1, 1'b1, 32'h100, 32'h9, 0, 32'h0);

    // SC to a different word fails
    data_access(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 0, 32'h0000_4321);
    data_access(1'b0, 1'b1, 1'b1, 32'h104, 32'h9, 0, 32'h0);

    // unrelated write keeps the link; same-word byte offset still matches
    data_access(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'h0000_0042);
    data_access(1'b0, 1'b1, 1'b0, 32'h200, 32'h3, 0, 32'h0);
    data_access(1'b0, 1'b1, 1'b1, 32'h102, 32'hCAFE, 0, 32'h0);

    // read and write together: write wins
    data_access(1'b1, 1'b1, 1'b0, 32'h50, 32'h9, 0, 32'h1234_5678);

    // arbitration under continuous data traffic
    @(negedge CLK);
    nRST = 1'b0;
    #1 nRST = 1'b1;
    @(negedge CLK);
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h500; daddr = 32'h400;
    ramstate = RS_ACCESS; ramload = 32'h0BAD_F00D;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge CLK);
      if (cyc == 20) dREN = 1'b0;
      if (cyc == 22) iREN = 1'b0;
      #1;
      exp1 = 2'b00; exp0 = 2'b00;
      if (cyc % 2 == 1 && cyc <= 19) begin
        g    = (cyc + 1) / 2;
        exp1 = (g % 2 == 1) ? 2'b01 : 2'b10;
        exp0 = 2'b01;
      end else if (cyc == 21) begin
        exp1 = 2'b10;
        exp0 = 2'b10;
      end
      chk($sformatf("fair1_hits_c%0d", cyc), {62'd0, ihit, dhit}, {62'd0, exp1});
      chk($sformatf("fair0_hits_c%0d", cyc), {62'd0, f0_ihit, f0_dhit}, {62'd0, exp0});
    end
    chk("fair1_iload", {32'd0, iload}, 64'd0);
    ramstate = RS_FREE;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
